// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse host: reset/enable handshake, packet framing, overflow saturation
// Produces the 25-bit packet word (toggle + Y + X + status) for the Zapper stage.
module ps2_mouse_ctrl #(
  parameter int INIT_TIMEOUT = 50_000_000,
  parameter int BYTE_TIMEOUT = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_done,
  output logic [24:0] ps2_mouse,
  output logic        ready
);

  typedef enum logic [2:0] {
    SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, STREAM
  } state_t;

  localparam int MAXT = (INIT_TIMEOUT > BYTE_TIMEOUT) ? INIT_TIMEOUT : BYTE_TIMEOUT;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_TIMEOUT - 1);

  state_t        state;
  state_t        wait_next;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [7:0]    b0, b1;
  logic [7:0]    expect_byte;
  logic [7:0]    b1_sat, b2_sat;

  always_comb begin
    expect_byte = 8'hFA;
    wait_next   = SEND_RST;
    case (state)
      WAIT_ACK1: begin expect_byte = 8'hFA; wait_next = WAIT_BAT;  end
      WAIT_BAT:  begin expect_byte = 8'hAA; wait_next = WAIT_ID;   end
      WAIT_ID:   begin expect_byte = 8'h00; wait_next = SEND_EN;   end
      WAIT_ACK2: begin expect_byte = 8'hFA; wait_next = STREAM;    end
      default:   begin expect_byte = 8'hFA; wait_next = SEND_RST;  end
    endcase
  end

  // Overflowed axes clamp to the 9-bit extreme matching their sign bit.
  always_comb begin
    b1_sat = b0[6] ? (b0[4] ? 8'h00 : 8'hFF) : b1;
    b2_sat = b0[7] ? (b0[5] ? 8'h00 : 8'hFF) : rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEND_RST;
      cnt       <= '0;
      idx       <= 2'd0;
      b0        <= 8'h00;
      b1        <= 8'h00;
      tx_data   <= 8'h00;
      tx_req    <= 1'b0;
      ps2_mouse <= 25'd0;
      ready     <= 1'b0;
    end else begin
      case (state)
        SEND_RST, SEND_EN: begin
          if (rx_error || (!(tx_req && tx_done) && cnt == INIT_LAST)) begin
            // Drop the request so the retry reissues FF cleanly.
            state  <= SEND_RST;
            cnt    <= '0;
            tx_req <= 1'b0;
          end else if (tx_req && tx_done) begin
            tx_req <= 1'b0;
            cnt    <= '0;
            state  <= (state == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
          end else begin
            cnt <= cnt + 1'b1;
            if (!tx_req) begin
              tx_req  <= 1'b1;
              tx_data <= (state == SEND_RST) ? 8'hFF : 8'hF4;
            end
          end
        end
        WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
          cnt <= '0;
          if (rx_error) begin
            state <= SEND_RST;
          end else if (rx_valid) begin
            if (rx_data == expect_byte) begin
              state <= wait_next;
              if (state == WAIT_ACK2) ready <= 1'b1;
            end else begin
              state <= SEND_RST;
            end
          end else if (cnt == INIT_LAST) begin
            state <= SEND_RST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STREAM: begin
          cnt <= '0;
          if (rx_error) begin
            idx <= 2'd0;
          end else if (rx_valid) begin
            case (idx)
              2'd0: begin
                if (rx_data[3]) begin
                  b0  <= rx_data;
                  idx <= 2'd1;
                end
              end
              2'd1: begin
                b1  <= rx_data;
                idx <= 2'd2;
              end
              default: begin
                ps2_mouse <= {~ps2_mouse[24], b2_sat, b1_sat, b0};
                idx       <= 2'd0;
              end
            endcase
          end else if (idx != 2'd0) begin
            if (cnt == BYTE_LAST) idx <= 2'd0;
            else                  cnt <= cnt + 1'b1;
          end
        end
        default: state <= SEND_RST;
      endcase
    end
  end

endmodule
